tick_gen: RTL and testbench

- Parametrised multi-channel tick generator, replacing fixed-rate divider blocks.
- Each channel emits a single-cycle enable pulse every DIV clk cycles.
- DIV is programmable at run time through a simple write port.
- Supports per-channel pause masking, global resync for phase alignment, and glitch-free divisor changes.
- Sits between the 100 MHz board clock and timekeeping, adjust, display-mux and blink logic.

---
 rtl/tick_gen_pkg.sv | 29 ++
 rtl/tick_gen_chan.sv | 88 ++++++++
 rtl/tick_gen.sv | 103 ++++++++++
 tb/tb_tick_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_gen_pkg                                                    |
// | Purpose  : Shared constants and helpers for the tick generator: default    |
// |            geometry, channel-select width and standard 100 MHz divisors.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tick_gen_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 27;

    // Channel-select width for the default channel count; never below 1 bit.
    localparam int CH_W = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

    // Divisors that produce standard tick rates from the 100 MHz board clock.
    localparam logic [26:0] DIV_1HZ   = 27'd100000000;
    localparam logic [26:0] DIV_2HZ   = 27'd50000000;
    localparam logic [26:0] DIV_5HZ   = 27'd20000000;
    localparam logic [26:0] DIV_200HZ = 27'd500000;

    // Select width for an arbitrary channel count (1 bit minimum).
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : tick_gen_pkg
`default_nettype wire

// File: rtl/tick_gen_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_chan                                                       |
// | Purpose  : One tick channel: counter, active divisor, wrap-time reload and |
// |            registered one-cycle tick pulse.                                |
// | Ports    : clk, rst      - clock / async active-high reset                 |
// |            freeze        - hold counter, suppress tick and reload          |
// |            resync        - restart at phase 0, load load_div               |
// |            shadow        - divisor picked up at the next wrap              |
// |            load_div      - divisor loaded on resync (write-forwarded)      |
// |            tick          - registered one-cycle pulse                      |
// |            sq            - 50% duty square wave (TICK_GEN_SQUARE_EN only)  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             resync,
    input  logic [CNT_W-1:0] shadow,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick
`ifdef TICK_GEN_SQUARE_EN
    ,
    output logic             sq
`endif
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic             r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= RST_DIV;
            r_tick   <= 1'b0;
        end else if (resync) begin
            r_cnt    <= '0;
            r_active <= load_div;
            r_tick   <= 1'b0;
        end else if (freeze) begin
            // Counter and divisor hold; only the pulse is suppressed.
            r_tick   <= 1'b0;
        end else if (r_active == '0) begin
            // Disabled: keep polling the shadow so a nonzero write restarts us.
            r_cnt    <= '0;
            r_active <= shadow;
            r_tick   <= 1'b0;
        end else if (r_cnt == (r_active - CNT_W'(1))) begin
            // Wrap: the only point where a new divisor is adopted.
            r_cnt    <= '0;
            r_active <= shadow;
            r_tick   <= 1'b1;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_tick   <= 1'b0;
        end
    end

    assign tick = r_tick;

`ifdef TICK_GEN_SQUARE_EN
    logic r_sq;

    // Toggle once per tick, giving a square wave at twice the tick period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq <= 1'b0;
        end else if (resync) begin
            r_sq <= 1'b0;
        end else begin
            r_sq <= r_sq ^ r_tick;
        end
    end

    assign sq = r_sq;
`else
    // Square-wave output not built.
`endif

endmodule : tick_chan
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_gen                                                        |
// | Purpose  : Multi-channel programmable tick generator. Holds the shadow     |
// |            divisor registers, write decode and readback mux; each channel  |
// |            is a tick_chan instance.                                        |
// | Ports    : clk, rst  - clock / async active-high reset                     |
// |            pause     - freezes channels selected by PAUSE_MASK             |
// |            resync    - restarts all channels at phase 0                    |
// |            wr_en/wr_ch/wr_div - shadow divisor write port                  |
// |            rd_ch/rd_div       - combinational shadow readback              |
// |            tick      - registered one-cycle pulses, one per channel        |
// |            sq        - square outputs, present only with macro             |
// |                        TICK_GEN_SQUARE_EN defined                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                        NUM_CH     = NUM_CH_DEF,
    parameter int                        CNT_W      = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0]   DEF_DIV    = {DIV_5HZ, DIV_200HZ, DIV_2HZ, DIV_1HZ},
    parameter logic [NUM_CH-1:0]         PAUSE_MASK = 4'b0011
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pause,
    input  logic                          resync,
    input  logic                          wr_en,
    input  logic [ch_width(NUM_CH)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]              wr_div,
    input  logic [ch_width(NUM_CH)-1:0]   rd_ch,
    output logic [CNT_W-1:0]              rd_div,
    output logic [NUM_CH-1:0]             tick
`ifdef TICK_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0]             sq
`endif
);

    localparam int c_ch_w = ch_width(NUM_CH);

    logic [CNT_W-1:0] r_shadow [NUM_CH];
    logic [NUM_CH-1:0] w_wr_hit;

    // Out-of-range wr_ch matches no channel and is therefore ignored.
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_hit[i] = wr_en && (wr_ch == c_ch_w'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= DEF_DIV[i*CNT_W +: CNT_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_hit[i]) begin
                    r_shadow[i] <= wr_div;
                end
            end
        end
    end

    always_comb begin
        rd_div = '0;
        if (int'(rd_ch) < NUM_CH) begin
            rd_div = r_shadow[rd_ch];
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] w_load_div;

            // A write coinciding with resync goes straight into the active
            // divisor so the channel restarts on the new rate.
            assign w_load_div = w_wr_hit[i] ? wr_div : r_shadow[i];

            tick_chan #(
                .CNT_W   (CNT_W),
                .RST_DIV (DEF_DIV[i*CNT_W +: CNT_W])
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .freeze   (pause & PAUSE_MASK[i]),
                .resync   (resync),
                .shadow   (r_shadow[i]),
                .load_div (w_load_div),
                .tick     (tick[i])
`ifdef TICK_GEN_SQUARE_EN
                ,
                .sq       (sq[i])
`endif
            );
        end
    endgenerate

endmodule : tick_gen
`default_nettype wire

// File: tb/tb_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tick_gen                                                     |
// | Purpose  : Directed self-checking bench for tick_gen (4 channels, 8-bit    |
// |            counters, reset divisors ch0..ch3 = 4,3,2,1). Covers the sq     |
// |            output when TICK_GEN_SQUARE_EN is defined.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tick_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pause = 1'b0;
    logic             resync = 1'b0;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_ch = '0;
    logic [CNT_W-1:0] wr_div = '0;
    logic [1:0]       rd_ch = '0;
    logic [CNT_W-1:0] rd_div;
    logic [3:0]       tick;
`ifdef TICK_GEN_SQUARE_EN
    logic [3:0]       sq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tick_gen #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEF_DIV    ({8'd1, 8'd2, 8'd3, 8'd4}),
        .PAUSE_MASK (4'b0011)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pause  (pause),
        .resync (resync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .rd_ch  (rd_ch),
        .rd_div (rd_div),
        .tick   (tick)
`ifdef TICK_GEN_SQUARE_EN
        ,
        .sq     (sq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset pattern with divisors 4,3,2,1: ticks on multiples of the divisor.
    function automatic logic [3:0] base_vec(input int k);
        return {1'b1, (k % 2) == 0, (k % 3) == 0, (k % 4) == 0};
    endfunction

    initial begin
        // ---------------- Reset values and basic divide pattern ------------
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("reset tick", 32'(tick), 32'h0);
        check("reset rd_div ch0", 32'(rd_div), 32'd4);
        rd_ch = 2'd3;
        #1;
        check("reset rd_div ch3", 32'(rd_div), 32'd1);
        rd_ch = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("s1 k=%0d", k), 32'(tick), 32'(base_vec(k)));
        end

        // ---------------- Divisor write takes effect at next wrap ----------
        do_reset();
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd6;
        step();
        wr_en = 1'b0;
        check("s2 rd_div after write", 32'(rd_div), 32'd6);
        check("s2 k=1", 32'(tick), 32'(base_vec(1)));
        for (int k = 2; k <= 16; k++) begin
            logic [3:0] e;
            step();
            e = base_vec(k);
            e[0] = (k == 4) || (k == 10) || (k == 16);
            check($sformatf("s2 k=%0d", k), 32'(tick), 32'(e));
        end

        // ---------------- Pause for 5 cycles mid-period --------------------
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            logic [3:0] e;
            step();
            e = base_vec(k);
            e[0] = (k >= 9) && (((k - 9) % 4) == 0);
            e[1] = (k >= 8) && (((k - 8) % 3) == 0);
            check($sformatf("s3 k=%0d", k), 32'(tick), 32'(e));
            if (k == 2) pause = 1'b1;
            if (k == 7) pause = 1'b0;
        end

        // ---------------- Divisor 0 disables, nonzero restarts -------------
        do_reset();
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd0;
        for (int k = 1; k <= 23; k++) begin
            step();
            wr_en = 1'b0;
            check($sformatf("s4 off k=%0d", k), 32'(tick[1]), 32'(k == 3));
        end
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd3;
        for (int k = 24; k <= 34; k++) begin
            step();
            wr_en = 1'b0;
            check($sformatf("s4 on k=%0d", k), 32'(tick[1]),
                  32'((k == 28) || (k == 31) || (k == 34)));
        end

        // ---------------- Resync with forwarded write ----------------------
        do_reset();
        repeat (5) step();
        resync = 1'b1; wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd5;
        step();
        resync = 1'b0; wr_en = 1'b0;
        rd_ch = 2'd2;
        #1;
        check("s5 resync tick", 32'(tick), 32'h0);
        check("s5 rd_div ch2", 32'(rd_div), 32'd5);
`ifdef TICK_GEN_SQUARE_EN
        check("s5 resync sq", 32'(sq), 32'h0);
`endif
        for (int j = 1; j <= 20; j++) begin
            logic [3:0] e;
            step();
            e = {1'b1, (j % 5) == 0, (j % 3) == 0, (j % 4) == 0};
            check($sformatf("s5 j=%0d", j), 32'(tick), 32'(e));
        end

        // ---------------- Asynchronous reset between edges -----------------
        check("s6 pre-reset tick3", 32'(tick[3]), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("s6 async tick", 32'(tick), 32'h0);
        check("s6 rd_div ch2 default", 32'(rd_div), 32'd2);
`ifdef TICK_GEN_SQUARE_EN
        check("s6 async sq", 32'(sq), 32'h0);
`endif
        rd_ch = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("s6 k=%0d", k), 32'(tick), 32'(base_vec(k)));
`ifdef TICK_GEN_SQUARE_EN
            // ch3 ticks every cycle from edge 1, so sq[3] toggles from edge 2.
            check($sformatf("s6 sq3 k=%0d", k), 32'(sq[3]), 32'(((k - 1) % 2) == 1));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tick_gen
`default_nettype wire
